// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with write-to-read bypass and a
// per-register busy scoreboard. Register 0 reads as zero; higher write port index wins.
module reg_file_mp #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 32,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [NUM_RD*AW-1:0]     ra_i,
   output logic [NUM_RD*WIDTH-1:0]  rd_o,
   output logic [NUM_RD-1:0]        rd_busy_o,
   input  logic [NUM_WR*AW-1:0]     wa_i,
   input  logic [NUM_WR*WIDTH-1:0]  wd_i,
   input  logic [NUM_WR-1:0]        we_i,
   input  logic                     busy_set_i,
   input  logic [AW-1:0]            busy_addr_i,
   input  logic                     flush_i
);

   logic [WIDTH-1:0] regs_r [DEPTH];
   logic [DEPTH-1:0] busy_r;

   logic [DEPTH-1:0] reg_we_s;
   logic [WIDTH-1:0] reg_wd_s [DEPTH];
   logic [DEPTH-1:0] busy_nxt_s;
   logic             whit_s;

   logic [AW-1:0]    rsel_s;
   logic [WIDTH-1:0] rdat_s;
   logic             rbsy_s;
   logic             rhit_s;

   // Per-register write decode; ports scanned in ascending order so the highest index wins.
   always_comb begin
      reg_we_s = '0;
      whit_s   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         reg_wd_s[i] = '0;
         for (int p = 0; p < NUM_WR; p++) begin
            whit_s      = we_i[p] && (wa_i[p*AW +: AW] == AW'(i)) && (i != 0);
            reg_we_s[i] = reg_we_s[i] | whit_s;
            reg_wd_s[i] = whit_s ? wd_i[p*WIDTH +: WIDTH] : reg_wd_s[i];
         end
      end
   end

   // Scoreboard next state: flush, then writeback clear, then issue set (set wins).
   always_comb begin
      busy_nxt_s              = flush_i ? '0 : busy_r;
      busy_nxt_s              = busy_nxt_s & ~reg_we_s;
      busy_nxt_s[busy_addr_i] = busy_nxt_s[busy_addr_i] | busy_set_i;
      busy_nxt_s[0]           = 1'b0;
   end

   // Combinational read ports with bypass of same-cycle writes.
   always_comb begin
      rd_o      = '0;
      rd_busy_o = '0;
      rsel_s    = '0;
      rdat_s    = '0;
      rbsy_s    = 1'b0;
      rhit_s    = 1'b0;
      for (int k = 0; k < NUM_RD; k++) begin
         rsel_s = ra_i[k*AW +: AW];
         rdat_s = regs_r[rsel_s];
         rbsy_s = busy_r[rsel_s];
         for (int p = 0; p < NUM_WR; p++) begin
            rhit_s = we_i[p] && (wa_i[p*AW +: AW] == rsel_s);
            rdat_s = rhit_s ? wd_i[p*WIDTH +: WIDTH] : rdat_s;
            rbsy_s = rbsy_s & ~rhit_s;
         end
         rd_o[k*WIDTH +: WIDTH] = (rsel_s == '0) ? '0 : rdat_s;
         rd_busy_o[k]           = (rsel_s != '0) & rbsy_s;
      end
   end

   // Register array and scoreboard state; reset discards any same-cycle write or set.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_r[i] <= '0;
         end
         busy_r <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (reg_we_s[i]) begin
               regs_r[i] <= reg_wd_s[i];
            end
         end
         busy_r <= busy_nxt_s;
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed test-plan steps followed by randomized cycles, all
// checked against an array-based reference model of the register file.
module tb_reg_file_mp;

   localparam int WIDTH  = 32;
   localparam int DEPTH  = 32;
   localparam int NUM_RD = 2;
   localparam int NUM_WR = 2;
   localparam int AW     = $clog2(DEPTH);

   logic                    clk = 1'b0;
   logic                    reset;
   logic [NUM_RD*AW-1:0]    ra;
   logic [NUM_RD*WIDTH-1:0] rd;
   logic [NUM_RD-1:0]       rd_busy;
   logic [NUM_WR*AW-1:0]    wa;
   logic [NUM_WR*WIDTH-1:0] wd;
   logic [NUM_WR-1:0]       we;
   logic                    busy_set;
   logic [AW-1:0]           busy_addr;
   logic                    flush;

   int vectors     = 0;
   int miscompares = 0;

   logic [WIDTH-1:0] m_mem  [DEPTH];
   bit               m_busy [DEPTH];

   always #5 clk = ~clk;

   reg_file_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
      .clk_i(clk), .reset_i(reset), .ra_i(ra), .rd_o(rd), .rd_busy_o(rd_busy),
      .wa_i(wa), .wd_i(wd), .we_i(we), .busy_set_i(busy_set),
      .busy_addr_i(busy_addr), .flush_i(flush));

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Reference read: stored value, overridden by the highest-index matching write.
   function automatic logic [WIDTH-1:0] m_read(input int a);
      logic [WIDTH-1:0] v;
      if (a == 0) return '0;
      v = m_mem[a];
      for (int p = 0; p < NUM_WR; p++)
         if (we[p] && int'(wa[p*AW +: AW]) == a) v = wd[p*WIDTH +: WIDTH];
      return v;
   endfunction

   function automatic logic m_busy_rd(input int a);
      logic b;
      if (a == 0) return 1'b0;
      b = m_busy[a];
      for (int p = 0; p < NUM_WR; p++)
         if (we[p] && int'(wa[p*AW +: AW]) == a) b = 1'b0;
      return b;
   endfunction

   task automatic settle();
      int a;
      #1;
      for (int k = 0; k < NUM_RD; k++) begin
         a = int'(ra[k*AW +: AW]);
         chk($sformatf("rd%0d@x%0d", k, a), rd[k*WIDTH +: WIDTH], m_read(a));
         chk($sformatf("busy%0d@x%0d", k, a), {31'b0, rd_busy[k]}, {31'b0, m_busy_rd(a)});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
         end
      end else begin
         for (int p = 0; p < NUM_WR; p++)
            if (we[p] && wa[p*AW +: AW] != '0) m_mem[wa[p*AW +: AW]] = wd[p*WIDTH +: WIDTH];
         if (flush)
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
         for (int p = 0; p < NUM_WR; p++)
            if (we[p]) m_busy[wa[p*AW +: AW]] = 1'b0;
         if (busy_set && busy_addr != '0) m_busy[busy_addr] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      reset = 1'b0; ra = '0; wa = '0; wd = '0; we = '0;
      busy_set = 1'b0; busy_addr = '0; flush = 1'b0;
   endtask

   task automatic set_ra(input int k, input int a);
      ra[k*AW +: AW] = AW'(a);
   endtask

   task automatic wr(input int p, input int a, input logic [WIDTH-1:0] d);
      we[p] = 1'b1;
      wa[p*AW +: AW] = AW'(a);
      wd[p*WIDTH +: WIDTH] = d;
   endtask

   task automatic read_pair(input int a0, input int a1);
      idle(); set_ra(0, a0); set_ra(1, a1); settle();
   endtask

   initial begin
      idle();
      reset = 1'b1;
      @(negedge clk);
      tick(); tick();
      idle();

      // Reset state: every register and busy bit reads zero.
      for (int a = 0; a < DEPTH; a += 2) begin
         read_pair(a, a + 1);
         chk("rst_rd0", rd[WIDTH-1:0], 32'h0);
         chk("rst_rd1", rd[2*WIDTH-1:WIDTH], 32'h0);
         chk("rst_busy", {30'b0, rd_busy}, 32'h0);
         tick();
      end

      // Writes to x0 are dropped.
      idle(); wr(0, 0, 32'hDEADBEEF); set_ra(0, 0); settle();
      chk("x0_bypass", rd[WIDTH-1:0], 32'h0);
      tick();
      read_pair(0, 0); chk("x0_read", rd[WIDTH-1:0], 32'h0); tick();

      // Dual write then read.
      idle(); wr(0, 5, 32'h12345678); wr(1, 6, 32'hCAFEF00D); settle(); tick();
      read_pair(5, 6);
      chk("x5_read", rd[WIDTH-1:0], 32'h12345678);
      chk("x6_read", rd[2*WIDTH-1:WIDTH], 32'hCAFEF00D);
      tick();

      // Collision: port 1 wins, both in bypass and storage.
      idle(); wr(0, 7, 32'h1111); wr(1, 7, 32'h2222); set_ra(0, 7); settle();
      chk("x7_coll_bypass", rd[WIDTH-1:0], 32'h2222);
      tick();
      read_pair(7, 7); chk("x7_coll_store", rd[WIDTH-1:0], 32'h2222); tick();
      idle(); wr(0, 7, 32'h3333); set_ra(1, 7); settle();
      chk("x7_bypass_p1", rd[2*WIDTH-1:WIDTH], 32'h3333);
      tick();

      // Scoreboard set and writeback clear.
      idle(); busy_set = 1'b1; busy_addr = AW'(9); settle(); tick();
      read_pair(9, 0); chk("x9_busy", {31'b0, rd_busy[0]}, 32'h1); tick();
      idle(); wr(0, 9, 32'hA5); set_ra(0, 9); settle();
      chk("x9_wb_busy", {31'b0, rd_busy[0]}, 32'h0);
      chk("x9_wb_data", rd[WIDTH-1:0], 32'hA5);
      tick();
      read_pair(9, 0); chk("x9_after_wb", {31'b0, rd_busy[0]}, 32'h0); tick();

      // Set wins over same-cycle writeback clear; set of x0 is ignored.
      idle(); busy_set = 1'b1; busy_addr = AW'(9); settle(); tick();
      idle(); wr(0, 9, 32'h5A); busy_set = 1'b1; busy_addr = AW'(9); set_ra(0, 9); settle(); tick();
      read_pair(9, 0); chk("x9_set_wins", {31'b0, rd_busy[0]}, 32'h1); tick();
      idle(); busy_set = 1'b1; busy_addr = '0; settle(); tick();
      read_pair(0, 0); chk("x0_never_busy", {30'b0, rd_busy}, 32'h0); tick();

      // Flush clears everything except a same-cycle set.
      idle(); busy_set = 1'b1; busy_addr = AW'(3); tick();
      busy_addr = AW'(4); tick();
      busy_addr = AW'(8); tick();
      idle(); flush = 1'b1; busy_set = 1'b1; busy_addr = AW'(10); settle(); tick();
      read_pair(3, 4);
      chk("flush_x3x4", {30'b0, rd_busy}, 32'h0); tick();
      read_pair(8, 10);
      chk("flush_x8", {31'b0, rd_busy[0]}, 32'h0);
      chk("flush_x10", {31'b0, rd_busy[1]}, 32'h1); tick();

      // Reset discards an in-flight write and clears busy.
      idle(); reset = 1'b1; wr(0, 3, 32'hFF); tick();
      read_pair(3, 10);
      chk("rst_drop_x3", rd[WIDTH-1:0], 32'h0);
      chk("rst_busy_x10", {31'b0, rd_busy[1]}, 32'h0); tick();
      read_pair(7, 5);
      chk("rst_clear_x7", rd[WIDTH-1:0], 32'h0); tick();

      // Randomized traffic on a narrow address range to provoke collisions.
      for (int n = 0; n < 400; n++) begin
         idle();
         we = NUM_WR'($urandom);
         for (int p = 0; p < NUM_WR; p++) begin
            wa[p*AW +: AW] = AW'($urandom_range(0, 7));
            wd[p*WIDTH +: WIDTH] = $urandom;
         end
         for (int k = 0; k < NUM_RD; k++) set_ra(k, int'($urandom_range(0, 7)));
         busy_set  = ($urandom_range(0, 2) == 0);
         busy_addr = AW'($urandom_range(0, 7));
         flush     = ($urandom_range(0, 15) == 0);
         reset     = ($urandom_range(0, 63) == 0);
         settle();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
